// File: rtl/match_fsm.sv
// Match controller for the N-player flappy game: ready-up lobby, timed countdown,
// per-player alive tracking with last-alive winner, and a game-over hold-off.
module match_fsm #(
    parameter  int NUM_PLAYERS = 2,
    parameter  int TICK_CYCLES = 65_000_000,
    parameter  int COUNTDOWN_S = 3,
    parameter  int HOLD_S      = 2,
    localparam int WW          = $clog2(NUM_PLAYERS + 1),
    localparam int CW          = $clog2(COUNTDOWN_S + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PLAYERS-1:0] click,
    input  logic [NUM_PLAYERS-1:0] dead,
    output logic [1:0]             state,
    output logic [NUM_PLAYERS-1:0] ready,
    output logic [NUM_PLAYERS-1:0] alive,
    output logic                   game_rst,
    output logic [NUM_PLAYERS-1:0] click_game,
    output logic [CW-1:0]          countdown,
    output logic                   winner_valid,
    output logic [WW-1:0]          winner_code,
    output logic [WW-1:0]          winner_latched
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HW = $clog2(HOLD_S + 1);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_COUNT = 2'b01,
        ST_PLAY  = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_PLAYERS-1:0] ready_q, ready_d;
    logic [NUM_PLAYERS-1:0] alive_q, alive_d;
    logic [NUM_PLAYERS-1:0] click_game_q, click_game_d;
    logic [CW-1:0]          countdown_q, countdown_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   game_rst_q, game_rst_d;
    logic                   winner_valid_q, winner_valid_d;
    logic [WW-1:0]          winner_code_q, winner_code_d;
    logic [WW-1:0]          winner_latched_q, winner_latched_d;

    logic                   tick_wrap;
    logic                   hold_done;
    logic [NUM_PLAYERS-1:0] alive_next;
    logic [WW-1:0]          alive_cnt;
    logic [WW-1:0]          last_code;

    assign tick_wrap  = (tick_q == TW'(TICK_CYCLES - 1));
    assign hold_done  = (hold_q == HW'(HOLD_S));
    assign alive_next = alive_q & ~dead;

    // Survivor count and the code of the highest survivor; with at most one
    // survivor that code is the winner, and zero survivors leaves it 0 (draw).
    always_comb begin
        alive_cnt = '0;
        last_code = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive_next[i]) begin
                alive_cnt = alive_cnt + WW'(1);
                last_code = WW'(i + 1);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        ready_d          = ready_q;
        alive_d          = alive_q;
        click_game_d     = '0;
        countdown_d      = countdown_q;
        tick_d           = tick_q;
        hold_d           = hold_q;
        game_rst_d       = 1'b0;
        winner_valid_d   = 1'b0;
        winner_code_d    = winner_code_q;
        winner_latched_d = winner_latched_q;

        unique case (state_q)
            ST_START: begin
                ready_d = ready_q | click;
                if (&ready_q) begin
                    state_d          = ST_COUNT;
                    game_rst_d       = 1'b1;
                    countdown_d      = CW'(COUNTDOWN_S);
                    tick_d           = '0;
                    alive_d          = '1;
                    winner_latched_d = '0;
                end
            end
            ST_COUNT: begin
                tick_d = tick_wrap ? '0 : tick_q + TW'(1);
                if (tick_wrap) begin
                    countdown_d = countdown_q - CW'(1);
                    if (countdown_q == CW'(1)) begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                click_game_d = click & alive_q & ~dead;
                alive_d      = alive_next;
                if (alive_cnt <= WW'(1)) begin
                    state_d          = ST_OVER;
                    winner_valid_d   = 1'b1;
                    winner_code_d    = last_code;
                    winner_latched_d = last_code;
                    hold_d           = '0;
                    tick_d           = '0;
                end
            end
            ST_OVER: begin
                tick_d = tick_wrap ? '0 : tick_q + TW'(1);
                if (tick_wrap && !hold_done) begin
                    hold_d = hold_q + HW'(1);
                end
                // The releasing click only leaves the state; it never counts as a ready click.
                if (hold_done && (|click)) begin
                    state_d = ST_START;
                    ready_d = '0;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_START;
            ready_q          <= '0;
            alive_q          <= '0;
            click_game_q     <= '0;
            countdown_q      <= '0;
            tick_q           <= '0;
            hold_q           <= '0;
            game_rst_q       <= 1'b0;
            winner_valid_q   <= 1'b0;
            winner_code_q    <= '0;
            winner_latched_q <= '0;
        end else begin
            state_q          <= state_d;
            ready_q          <= ready_d;
            alive_q          <= alive_d;
            click_game_q     <= click_game_d;
            countdown_q      <= countdown_d;
            tick_q           <= tick_d;
            hold_q           <= hold_d;
            game_rst_q       <= game_rst_d;
            winner_valid_q   <= winner_valid_d;
            winner_code_q    <= winner_code_d;
            winner_latched_q <= winner_latched_d;
        end
    end

    assign state          = state_q;
    assign ready          = ready_q;
    assign alive          = alive_q;
    assign click_game     = click_game_q;
    assign countdown      = countdown_q;
    assign game_rst       = game_rst_q;
    assign winner_valid   = winner_valid_q;
    assign winner_code    = winner_code_q;
    assign winner_latched = winner_latched_q;

endmodule

// File: tb/tb_match_fsm.sv
// Directed bench for match_fsm with 2 players, 4-cycle ticks, 3-tick countdown, 1-tick hold.
module tb_match_fsm;

    localparam int NP = 2;
    localparam int TC = 4;
    localparam int CD = 3;
    localparam int HS = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NP-1:0] click = '0;
    logic [NP-1:0] dead = '0;
    logic [1:0]    state;
    logic [NP-1:0] ready;
    logic [NP-1:0] alive;
    logic          game_rst;
    logic [NP-1:0] click_game;
    logic [1:0]    countdown;
    logic          winner_valid;
    logic [1:0]    winner_code;
    logic [1:0]    winner_latched;

    int errors = 0;
    int checks = 0;

    match_fsm #(
        .NUM_PLAYERS(NP),
        .TICK_CYCLES(TC),
        .COUNTDOWN_S(CD),
        .HOLD_S(HS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .click(click),
        .dead(dead),
        .state(state),
        .ready(ready),
        .alive(alive),
        .game_rst(game_rst),
        .click_game(click_game),
        .countdown(countdown),
        .winner_valid(winner_valid),
        .winner_code(winner_code),
        .winner_latched(winner_latched)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From START with nobody ready: both click, then 1 cycle to COUNTDOWN, then 12 to PLAY.
    task automatic run_to_play();
        click = 2'b11; step();
        click = 2'b00; step();
        repeat (CD * TC) step();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state); end
        checks++; if ({ready, alive, countdown} !== 6'b0) begin errors++; $display("FAIL reset_regs: got ready=%b alive=%b countdown=%0d want 0", ready, alive, countdown); end
        checks++; if ({game_rst, winner_valid, click_game, winner_code, winner_latched} !== 8'b0) begin errors++; $display("FAIL reset_pulses: got gr=%b wv=%b cg=%b wc=%0d wl=%0d want 0", game_rst, winner_valid, click_game, winner_code, winner_latched); end
        @(negedge clk); rst = 1'b1;
        step();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_release_state: got %b want 00", state); end
    endtask

    task automatic test_lobby_countdown();
        click = 2'b01; step();
        checks++; if (ready !== 2'b01) begin errors++; $display("FAIL lobby_ready1: got %b want 01", ready); end
        click = 2'b01; step();
        checks++; if (ready !== 2'b01) begin errors++; $display("FAIL lobby_ready2: got %b want 01", ready); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL lobby_state2: got %b want 00", state); end
        click = 2'b10; step();
        checks++; if (ready !== 2'b11) begin errors++; $display("FAIL lobby_ready3: got %b want 11", ready); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL lobby_state3: got %b want 00", state); end
        click = 2'b00; step();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL cd_entry_state: got %b want 01", state); end
        checks++; if (game_rst !== 1'b1) begin errors++; $display("FAIL cd_game_rst: got %b want 1", game_rst); end
        checks++; if (countdown !== 2'd3) begin errors++; $display("FAIL cd_load: got %0d want 3", countdown); end
        checks++; if (alive !== 2'b11) begin errors++; $display("FAIL cd_alive: got %b want 11", alive); end
        click = 2'b11; dead = 2'b11; step();
        click = 2'b00; dead = 2'b00;
        checks++; if (game_rst !== 1'b0) begin errors++; $display("FAIL cd_game_rst_end: got %b want 0", game_rst); end
        checks++; if (click_game !== 2'b00) begin errors++; $display("FAIL cd_click_ignored: got %b want 00", click_game); end
        checks++; if (alive !== 2'b11) begin errors++; $display("FAIL cd_dead_ignored: got %b want 11", alive); end
        step(); step();
        checks++; if (countdown !== 2'd3) begin errors++; $display("FAIL cd_hold3: got %0d want 3", countdown); end
        step();
        checks++; if (countdown !== 2'd2) begin errors++; $display("FAIL cd_step2: got %0d want 2", countdown); end
        repeat (4) step();
        checks++; if (countdown !== 2'd1) begin errors++; $display("FAIL cd_step1: got %0d want 1", countdown); end
        repeat (3) step();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL cd_last_cycle: got %b want 01", state); end
        step();
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL play_entry: got %b want 10", state); end
        checks++; if (countdown !== 2'd0) begin errors++; $display("FAIL play_countdown: got %0d want 0", countdown); end
    endtask

    task automatic test_single_death();
        dead = 2'b10; step();
        dead = 2'b00;
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL death_state: got %b want 11", state); end
        checks++; if (winner_valid !== 1'b1) begin errors++; $display("FAIL death_valid: got %b want 1", winner_valid); end
        checks++; if (winner_code !== 2'd1) begin errors++; $display("FAIL death_code: got %0d want 1", winner_code); end
        checks++; if (winner_latched !== 2'd1) begin errors++; $display("FAIL death_latched: got %0d want 1", winner_latched); end
        checks++; if (alive !== 2'b01) begin errors++; $display("FAIL death_alive: got %b want 01", alive); end
        step();
        checks++; if (winner_valid !== 1'b0) begin errors++; $display("FAIL death_valid_end: got %b want 0", winner_valid); end
    endtask

    // Entered GAMEOVER at edge E; now at E+1. Hold-off ends at E+4.
    task automatic test_holdoff();
        click = 2'b01; step();
        click = 2'b00;
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL hold_early_click: got %b want 11", state); end
        step();
        click = 2'b10; step();
        click = 2'b00;
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL hold_edge_click: got %b want 11", state); end
        checks++; if (alive !== 2'b01) begin errors++; $display("FAIL hold_alive_frozen: got %b want 01", alive); end
        click = 2'b01; step();
        click = 2'b00;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL hold_release: got %b want 00", state); end
        checks++; if (ready !== 2'b00) begin errors++; $display("FAIL hold_ready_clear: got %b want 00", ready); end
        checks++; if (winner_latched !== 2'd1) begin errors++; $display("FAIL hold_latched_kept: got %0d want 1", winner_latched); end
    endtask

    task automatic test_relobby();
        click = 2'b11; step();
        click = 2'b00;
        checks++; if (winner_latched !== 2'd1) begin errors++; $display("FAIL relobby_latched: got %0d want 1", winner_latched); end
        step();
        checks++; if (game_rst !== 1'b1) begin errors++; $display("FAIL relobby_game_rst: got %b want 1", game_rst); end
        checks++; if (winner_latched !== 2'd0) begin errors++; $display("FAIL relobby_latched_clear: got %0d want 0", winner_latched); end
        repeat (CD * TC) step();
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL relobby_play: got %b want 10", state); end
    endtask

    task automatic test_click_gating();
        click = 2'b10; step();
        checks++; if (click_game !== 2'b10) begin errors++; $display("FAIL gate_p1: got %b want 10", click_game); end
        click = 2'b01; step();
        checks++; if (click_game !== 2'b01) begin errors++; $display("FAIL gate_p0: got %b want 01", click_game); end
        click = 2'b00; step();
        checks++; if (click_game !== 2'b00) begin errors++; $display("FAIL gate_idle: got %b want 00", click_game); end
        click = 2'b11; dead = 2'b01; step();
        click = 2'b00; dead = 2'b00;
        checks++; if (click_game !== 2'b10) begin errors++; $display("FAIL gate_dying: got %b want 10", click_game); end
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL gate_over_state: got %b want 11", state); end
        checks++; if (winner_code !== 2'd2) begin errors++; $display("FAIL gate_winner: got %0d want 2", winner_code); end
        click = 2'b01; step();
        click = 2'b00;
        checks++; if (click_game !== 2'b00) begin errors++; $display("FAIL gate_over_click: got %b want 00", click_game); end
        repeat (4) step();
        click = 2'b10; step();
        click = 2'b00;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL gate_exit: got %b want 00", state); end
    endtask

    task automatic test_simultaneous();
        run_to_play();
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL sim_play: got %b want 10", state); end
        click = 2'b11; dead = 2'b11; step();
        click = 2'b00; dead = 2'b00;
        checks++; if (click_game !== 2'b00) begin errors++; $display("FAIL sim_click_game: got %b want 00", click_game); end
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL sim_state: got %b want 11", state); end
        checks++; if (winner_valid !== 1'b1) begin errors++; $display("FAIL sim_valid: got %b want 1", winner_valid); end
        checks++; if (winner_code !== 2'd0) begin errors++; $display("FAIL sim_draw: got %0d want 0", winner_code); end
        step();
        checks++; if (winner_valid !== 1'b0) begin errors++; $display("FAIL sim_valid_once: got %b want 0", winner_valid); end
    endtask

    task automatic test_async_reset();
        #2; rst = 1'b0; #1;
        checks++; if ({state, ready, alive} !== 6'b0) begin errors++; $display("FAIL areset_over: got state=%b ready=%b alive=%b want 0", state, ready, alive); end
        @(negedge clk); rst = 1'b1;
        click = 2'b11; step();
        click = 2'b00; step();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL areset_cd_entry: got %b want 01", state); end
        repeat (5) step();
        #2; rst = 1'b0; #1;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL areset_cd_state: got %b want 00", state); end
        checks++; if ({countdown, alive, ready, game_rst} !== 7'b0) begin errors++; $display("FAIL areset_cd_regs: got cd=%0d alive=%b ready=%b gr=%b want 0", countdown, alive, ready, game_rst); end
        @(negedge clk); rst = 1'b1;
        step();
        checks++; if ({state, ready} !== 4'b0) begin errors++; $display("FAIL areset_release: got state=%b ready=%b want 0", state, ready); end
    endtask

    initial begin
        test_reset();
        test_lobby_countdown();
        test_single_death();
        test_holdoff();
        test_relobby();
        test_click_gating();
        test_simultaneous();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
